// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared state encoding and constants for the divider arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int DIV_W = 8;
  localparam logic [DIV_W-1:0] DBZ_QUOTIENT = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick: first asserted request at or
//               after ptr, searching upward with wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_idx,
  output logic            gnt_vld
);

  function automatic logic [ID_W-1:0] rot_idx(input logic [ID_W-1:0] base, input int ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= N) s = s - N;
    return ID_W'(s);
  endfunction

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!gnt_vld && req[rot_idx(ptr, i)]) begin
        gnt_vld               = 1'b1;
        gnt_idx               = rot_idx(ptr, i);
        gnt[rot_idx(ptr, i)]  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/div_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : div_arbiter
// Description : Round-robin sequencer sharing one iterative 8-bit divider
//               among N requesters. Option macro: DIV_ARB_DBZ_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module div_arbiter
  import div_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  output logic [N-1:0]         req_ready,
  input  logic [N*DIV_W-1:0]   req_dividend,
  input  logic [N*DIV_W-1:0]   req_divisor,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [DIV_W-1:0]     rsp_quotient,
  output logic [DIV_W-1:0]     rsp_remainder,
  output logic                 rsp_dbz,
  output logic                 div_strt,
  output logic [DIV_W-1:0]     div_dividend,
  output logic [DIV_W-1:0]     div_divisor,
  input  logic [DIV_W-1:0]     div_quotient,
  input  logic [DIV_W-1:0]     div_remainder,
  input  logic                 div_idle
);

  state_t            r_state;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_id;
  logic [DIV_W-1:0]  r_dividend;
  logic [DIV_W-1:0]  r_divisor;
  logic              r_first;
  logic              r_rsp_valid;
  logic [DIV_W-1:0]  r_rsp_q;
  logic [DIV_W-1:0]  r_rsp_r;
  logic              r_rsp_dbz;

  logic [N-1:0]      w_gnt;
  logic [ID_W-1:0]   w_gnt_idx;
  logic              w_gnt_vld;
  logic              w_grant;
  logic              w_dbz;

  rr_arbiter #(.N(N), .ID_W(ID_W)) u_rr (
    .req     (req_valid),
    .ptr     (r_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .gnt_vld (w_gnt_vld)
  );

  assign w_grant   = (r_state == ST_IDLE) && div_idle && w_gnt_vld;
  assign req_ready = w_grant ? w_gnt : '0;
  assign w_dbz     = (r_divisor == '0);

`ifdef DIV_ARB_DBZ_BYPASS_EN
  assign div_strt = (r_state == ST_ISSUE) && !w_dbz;
`else
  assign div_strt = (r_state == ST_ISSUE);
`endif

  assign div_dividend  = r_dividend;
  assign div_divisor   = r_divisor;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_id        = r_id;
  assign rsp_quotient  = r_rsp_q;
  assign rsp_remainder = r_rsp_r;
  assign rsp_dbz       = r_rsp_dbz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_id        <= '0;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_first     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_q     <= '0;
      r_rsp_r     <= '0;
      r_rsp_dbz   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_dividend <= req_dividend[int'(w_gnt_idx)*DIV_W +: DIV_W];
            r_divisor  <= req_divisor[int'(w_gnt_idx)*DIV_W +: DIV_W];
            r_id       <= w_gnt_idx;
            r_ptr      <= (w_gnt_idx == ID_W'(N-1)) ? '0 : w_gnt_idx + 1'b1;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
`ifdef DIV_ARB_DBZ_BYPASS_EN
          if (w_dbz) begin
            r_rsp_q     <= DBZ_QUOTIENT;
            r_rsp_r     <= r_dividend;
            r_rsp_dbz   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else
`endif
          begin
            r_first <= 1'b1;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // First WAIT cycle still shows the divider's pre-start idle level
          r_first <= 1'b0;
          if (!r_first && div_idle) begin
            r_rsp_q     <= w_dbz ? DBZ_QUOTIENT : div_quotient;
            r_rsp_r     <= w_dbz ? r_dividend   : div_remainder;
            r_rsp_dbz   <= w_dbz;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_arbiter
// Description : Directed self-checking bench for div_arbiter with a
//               variable-latency divider model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_arbiter;

  localparam int N    = 4;
  localparam int ID_W = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*8-1:0]  req_dividend;
  logic [N*8-1:0]  req_divisor;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [ID_W-1:0] rsp_id;
  logic [7:0]      rsp_quotient;
  logic [7:0]      rsp_remainder;
  logic            rsp_dbz;
  logic            div_strt;
  logic [7:0]      div_dividend;
  logic [7:0]      div_divisor;
  logic [7:0]      div_quotient;
  logic [7:0]      div_remainder;
  logic            div_idle;

  always #5 clk = ~clk;

  div_arbiter #(.N(N), .ID_W(ID_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .rsp_dbz       (rsp_dbz),
    .div_strt      (div_strt),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .div_idle      (div_idle)
  );

  // Divider model: busy for lat cycles after start; junk outputs while busy
  // and on a zero divisor so the arbiter's override is exercised.
  int         lat;
  int         cnt;
  logic [7:0] m_q;
  logic [7:0] m_r;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 0;
      m_q <= 8'h00;
      m_r <= 8'h00;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
    end else if (div_strt) begin
      cnt <= lat;
      if (div_divisor == 8'd0) begin
        m_q <= 8'hAA;
        m_r <= 8'h55;
      end else begin
        m_q <= div_dividend / div_divisor;
        m_r <= div_dividend % div_divisor;
      end
    end
  end

  assign div_idle      = (cnt == 0);
  assign div_quotient  = div_idle ? m_q : 8'h5A;
  assign div_remainder = div_idle ? m_r : 8'hA5;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int gnt_q[$];
  int rid_q[$];
  int rq_q[$];
  int rr_q[$];
  int rd_q[$];
  int strt_cnt;
  int gnt_cyc;
  int rv_cyc;
  bit auto_drop;
  bit busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    gnt_q.delete(); rid_q.delete(); rq_q.delete(); rr_q.delete(); rd_q.delete();
    strt_cnt = 0;
    gnt_cyc  = -1;
    rv_cyc   = -1;
  endtask

  // Sample mid-cycle, then advance to 1 time unit after the next rising edge.
  task automatic tick();
    logic [N-1:0] rdy;
    #3;
    rdy = req_ready;
    if (|rdy) begin
      check("grant_onehot", $countones(rdy), 1);
      check("grant_while_busy", {31'd0, busy}, 0);
      busy = 1'b1;
      for (int i = 0; i < N; i++) if (rdy[i]) gnt_q.push_back(i);
      if (gnt_cyc < 0) gnt_cyc = cyc;
    end
    if (div_strt) strt_cnt++;
    if (rsp_valid && rv_cyc < 0) rv_cyc = cyc;
    if (rsp_valid && rsp_ready) begin
      rid_q.push_back(int'(rsp_id));
      rq_q.push_back(int'(rsp_quotient));
      rr_q.push_back(int'(rsp_remainder));
      rd_q.push_back(int'(rsp_dbz));
      busy = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (auto_drop) req_valid = req_valid & ~rdy;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
    req_dividend[8*i +: 8] = a;
    req_divisor[8*i +: 8]  = b;
    req_valid[i]           = 1'b1;
  endtask

  task automatic wait_rsp(input int n, input int budget);
    for (int k = 0; k < budget && rid_q.size() < n; k++) tick();
    if (rid_q.size() < n) check("rsp_timeout", rid_q.size(), n);
  endtask

  task automatic check_rsp(input string tag, input int k, input int id, input int q, input int r, input int d);
    if (rid_q.size() > k) begin
      check({tag, "_id"},  rid_q[k], id);
      check({tag, "_q"},   rq_q[k],  q);
      check({tag, "_r"},   rr_q[k],  r);
      check({tag, "_dbz"}, rd_q[k],  d);
    end else begin
      check({tag, "_missing"}, rid_q.size(), k + 1);
    end
  endtask

  task automatic check_gnt(input string tag, input int k, input int id);
    if (gnt_q.size() > k) check(tag, gnt_q[k], id);
    else check({tag, "_missing"}, gnt_q.size(), k + 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {28'd0, req_ready}, 0);
    check({tag, "_div_strt"},  {31'd0, div_strt}, 0);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 0);
    check({tag, "_rsp_id"},    {30'd0, rsp_id}, 0);
    check({tag, "_rsp_q"},     {24'd0, rsp_quotient}, 0);
    check({tag, "_rsp_r"},     {24'd0, rsp_remainder}, 0);
    check({tag, "_rsp_dbz"},   {31'd0, rsp_dbz}, 0);
    check({tag, "_div_a"},     {24'd0, div_dividend}, 0);
    check({tag, "_div_b"},     {24'd0, div_divisor}, 0);
  endtask

  int stall_err;
  logic [7:0] snap_q, snap_r;
  logic [ID_W-1:0] snap_id;

  initial begin
    rst          = 1'b1;
    req_valid    = '0;
    req_dividend = '0;
    req_divisor  = '0;
    rsp_ready    = 1'b0;
    lat          = 5;
    auto_drop    = 1'b1;
    busy         = 1'b0;
    clear_log();

    // Reset state
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Single request: 200/7 on requester 2
    clear_log();
    rsp_ready = 1'b1;
    set_req(2, 8'd200, 8'd7);
    wait_rsp(1, 60);
    repeat (3) tick();
    check("single_ngrant", gnt_q.size(), 1);
    check_gnt("single_gnt", 0, 2);
    check("single_strt", strt_cnt, 1);
    check("single_latency", rv_cyc - gnt_cyc, 8);
    check("single_nrsp", rid_q.size(), 1);
    check_rsp("single", 0, 2, 28, 4, 0);

    // Divide by zero: 55/0 on requester 1
    clear_log();
    set_req(1, 8'd55, 8'd0);
    wait_rsp(1, 60);
    repeat (2) tick();
    check_gnt("dbz_gnt", 0, 1);
`ifdef DIV_ARB_DBZ_BYPASS_EN
    check("dbz_strt", strt_cnt, 0);
    check("dbz_latency", rv_cyc - gnt_cyc, 2);
`else
    check("dbz_strt", strt_cnt, 1);
    check("dbz_latency", rv_cyc - gnt_cyc, 8);
`endif
    check_rsp("dbz", 0, 1, 255, 55, 1);

    // Backpressure: 9/3 on requester 0, requester 3 waits behind it
    clear_log();
    rsp_ready = 1'b0;
    set_req(0, 8'd9, 8'd3);
    for (int k = 0; k < 60 && !rsp_valid; k++) tick();
    check("bp_valid", {31'd0, rsp_valid}, 1);
    set_req(3, 8'd9, 8'd9);
    snap_q    = rsp_quotient;
    snap_r    = rsp_remainder;
    snap_id   = rsp_id;
    stall_err = 0;
    repeat (10) begin
      tick();
      if (!rsp_valid || rsp_quotient !== snap_q || rsp_remainder !== snap_r || rsp_id !== snap_id)
        stall_err++;
    end
    check("bp_stable", stall_err, 0);
    check("bp_q", {24'd0, snap_q}, 3);
    check("bp_r", {24'd0, snap_r}, 0);
    check("bp_no_grant", gnt_q.size(), 1);
    rsp_ready = 1'b1;
    wait_rsp(2, 60);
    check_gnt("bp_gnt0", 0, 0);
    check_gnt("bp_gnt1", 1, 3);
    check_rsp("bp_a", 0, 0, 3, 0, 0);
    check_rsp("bp_b", 1, 3, 1, 0, 0);

    // Round robin: all four continuously valid, ptr starts at 0
    clear_log();
    lat       = 3;
    auto_drop = 1'b0;
    set_req(0, 8'd100, 8'd10);
    set_req(1, 8'd77,  8'd5);
    set_req(2, 8'd13,  8'd200);
    set_req(3, 8'd255, 8'd16);
    wait_rsp(5, 200);
    req_valid = '0;
    auto_drop = 1'b1;
    repeat (3) tick();
    check("rr_ngrant", gnt_q.size(), 5);
    check_gnt("rr_gnt0", 0, 0);
    check_gnt("rr_gnt1", 1, 1);
    check_gnt("rr_gnt2", 2, 2);
    check_gnt("rr_gnt3", 3, 3);
    check_gnt("rr_gnt4", 4, 0);
    check_rsp("rr0", 0, 0, 10, 0, 0);
    check_rsp("rr1", 1, 1, 15, 2, 0);
    check_rsp("rr2", 2, 2, 0, 13, 0);
    check_rsp("rr3", 3, 3, 15, 15, 0);
    check_rsp("rr4", 4, 0, 10, 0, 0);

    // Reset mid-WAIT: grant to requester 2 moves ptr to 3 before reset
    clear_log();
    lat = 20;
    set_req(2, 8'd255, 8'd1);
    for (int k = 0; k < 20 && gnt_cyc < 0; k++) tick();
    check_gnt("mid_gnt", 0, 2);
    repeat (4) tick();
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    tick();
    rst  = 1'b0;
    busy = 1'b0;
    clear_log();
    repeat (5) tick();
    check("midrst_norsp", rid_q.size(), 0);

    // After reset ptr=0 so requester 1 wins over 3; divisor >= 128 with a
    // one-cycle divider exercises capture on the earliest idle rise.
    clear_log();
    lat = 1;
    set_req(1, 8'd255, 8'd1);
    set_req(3, 8'd250, 8'd130);
    wait_rsp(2, 60);
    check_gnt("post_gnt0", 0, 1);
    check_gnt("post_gnt1", 1, 3);
    check("post_latency", rv_cyc - gnt_cyc, 4);
    check_rsp("post_a", 0, 1, 255, 0, 0);
    check_rsp("post_b", 1, 3, 1, 120, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
